// File: rtl/vec_operand_loader_if.sv
// Handshake bundle between the operand fetch stream and the dot-product datapath.
// The loader uses the slave modport; the fetch/datapath side uses master.
interface vec_operand_loader_if #(
    parameter int BIT_WIDTH = 4,
    parameter int VEC_SIZE  = 64,
    parameter int BUS_WIDTH = 32
);
    localparam int VEC_WIDTH = BIT_WIDTH * VEC_SIZE;

    logic                 i_valid;
    logic                 o_ready;
    logic [BUS_WIDTH-1:0] i_data;
    logic                 i_last;
    logic                 o_valid;
    logic                 i_ready;
    logic [VEC_WIDTH-1:0] o_a;
    logic [VEC_WIDTH-1:0] o_b;

    modport slave (
        input  i_valid, i_data, i_last, i_ready,
        output o_ready, o_valid, o_a, o_b
    );

    modport master (
        output i_valid, i_data, i_last, i_ready,
        input  o_ready, o_valid, o_a, o_b
    );
endinterface

// File: rtl/vec_operand_loader.sv
// Assembles an A vector then a B vector from narrow beats and presents the pair downstream.
// Optional early end-of-vector with zero fill: define VEC_OPERAND_LOADER_ZERO_PAD_EN.
module vec_operand_loader #(
    parameter int BIT_WIDTH = 4,
    parameter int VEC_SIZE  = 64,
    parameter int BUS_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    vec_operand_loader_if.slave   bus
);
    localparam int VEC_WIDTH = BIT_WIDTH * VEC_SIZE;
    localparam int BEATS     = VEC_WIDTH / BUS_WIDTH;
    localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    localparam logic [1:0] S_LOAD_A = 2'd0;
    localparam logic [1:0] S_LOAD_B = 2'd1;
    localparam logic [1:0] S_OUT    = 2'd2;

    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_beat_cnt;
    logic [VEC_WIDTH-1:0] r_a;
    logic [VEC_WIDTH-1:0] r_b;
    logic [VEC_WIDTH-1:0] w_fill;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_pad;
    logic                 w_end_vec;

    assign w_ready  = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign w_accept = bus.i_valid && w_ready;

`ifdef VEC_OPERAND_LOADER_ZERO_PAD_EN
    assign w_pad = bus.i_last && (r_beat_cnt != LAST_CNT);
`else
    assign w_pad = 1'b0;
`endif

    assign w_end_vec = (r_beat_cnt == LAST_CNT) || w_pad;

    // Next image of the buffer being filled: current beat slot written, and on an
    // early end every higher slot cleared so padded elements multiply to zero.
    always_comb begin
        // NOTE: default first so no path through the loop leaves w_fill unassigned (no latch).
        w_fill = (r_state == S_LOAD_B) ? r_b : r_a;
        for (int j = 0; j < BEATS; j++) begin
            if (CNT_W'(j) == r_beat_cnt) begin
                w_fill[j*BUS_WIDTH +: BUS_WIDTH] = bus.i_data;
            end else if (w_pad && (CNT_W'(j) > r_beat_cnt)) begin
                w_fill[j*BUS_WIDTH +: BUS_WIDTH] = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_LOAD_A;
            r_beat_cnt <= '0;
            // NOTE: the operand buffers are registers, not RAM, so clearing them on reset is cheap.
            r_a        <= '0;
            r_b        <= '0;
        end else begin
            case (r_state)
                S_LOAD_A: begin
                    if (w_accept) begin
                        r_a <= w_fill;
                        if (w_end_vec) begin
                            r_beat_cnt <= '0;
                            r_state    <= S_LOAD_B;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (w_accept) begin
                        r_b <= w_fill;
                        if (w_end_vec) begin
                            r_beat_cnt <= '0;
                            r_state    <= S_OUT;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.i_ready) begin
                        r_state <= S_LOAD_A;
                    end
                end
                default: r_state <= S_LOAD_A;
            endcase
        end
    end

    assign bus.o_ready = w_ready;
    assign bus.o_valid = (r_state == S_OUT);
    assign bus.o_a     = r_a;
    assign bus.o_b     = r_b;
endmodule

// File: tb/tb_vec_operand_loader.sv
// Self-checking bench for vec_operand_loader: random beats against a queue-based pair model.
// Build with VEC_OPERAND_LOADER_ZERO_PAD_EN defined to also exercise early end-of-vector.
module tb_vec_operand_loader;
    localparam int BIT_WIDTH = 4;
    localparam int VEC_SIZE  = 64;
    localparam int BUS_WIDTH = 32;
    localparam int VEC_WIDTH = BIT_WIDTH * VEC_SIZE;
    localparam int BEATS     = VEC_WIDTH / BUS_WIDTH;

    typedef logic [BUS_WIDTH-1:0] beat_t;
    typedef beat_t beats_t [BEATS];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec_operand_loader_if #(.BIT_WIDTH(BIT_WIDTH), .VEC_SIZE(VEC_SIZE), .BUS_WIDTH(BUS_WIDTH)) bus ();

    vec_operand_loader #(.BIT_WIDTH(BIT_WIDTH), .VEC_SIZE(VEC_SIZE), .BUS_WIDTH(BUS_WIDTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [VEC_WIDTH-1:0] got, input logic [VEC_WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: accepted beats collected per vector, pair published once B completes.
    beat_t                qa[$];
    beat_t                qb[$];
    bit                   a_done     = 1'b0;
    bit                   m_pending  = 1'b0;
    bit                   m_accepted = 1'b0;
    logic [VEC_WIDTH-1:0] ea, eb;
    int                   cyc = 0;
    int                   acc_since_rst = 0;
    int                   rises[$];
    logic                 prev_valid = 1'b0;

    function automatic logic [VEC_WIDTH-1:0] pack(input beat_t q[$]);
        logic [VEC_WIDTH-1:0] r = '0;
        foreach (q[k]) r[k*BUS_WIDTH +: BUS_WIDTH] = q[k];
        return r;
    endfunction

    task automatic model_push(input beat_t d, input bit lst);
        bit end_v;
`ifdef VEC_OPERAND_LOADER_ZERO_PAD_EN
        end_v = lst;
`else
        end_v = 1'b0;
`endif
        if (!a_done) begin
            qa.push_back(d);
            if (qa.size() == BEATS || end_v) a_done = 1'b1;
        end else begin
            qb.push_back(d);
            if (qb.size() == BEATS || end_v) begin
                m_pending = 1'b1;
                ea = pack(qa);
                eb = pack(qb);
            end
        end
    endtask

    task automatic cycle();
        bit    acc, xfer, lst;
        beat_t d;
        acc  = bus.i_valid && !m_pending && !rst;
        xfer = m_pending && bus.i_ready && !rst;
        d    = bus.i_data;
        lst  = bus.i_last;
        @(posedge clk);
        #1;
        cyc++;
        m_accepted = acc;
        if (rst) begin
            qa.delete(); qb.delete();
            a_done = 1'b0; m_pending = 1'b0; acc_since_rst = 0;
        end else if (xfer) begin
            qa.delete(); qb.delete();
            a_done = 1'b0; m_pending = 1'b0;
        end else if (acc) begin
            acc_since_rst++;
            model_push(d, lst);
        end
        check("o_valid", bus.o_valid, m_pending);
        check("o_ready", bus.o_ready, !m_pending);
        if (m_pending) begin
            check("o_a", bus.o_a, ea);
            check("o_b", bus.o_b, eb);
        end
        if (bus.o_valid && !prev_valid) rises.push_back(cyc);
        prev_valid = bus.o_valid;
    endtask

    // Offers one beat until accepted; gap_pct is the chance of an idle cycle before each offer.
    task automatic send_beat(input beat_t d, input bit lst, input int gap_pct);
        int tries = 0;
        bit done  = 1'b0;
        while (!done) begin
            if ($urandom_range(99) < gap_pct) begin
                bus.i_valid = 1'b0;
                bus.i_data  = $urandom;
                bus.i_last  = 1'b0;
            end else begin
                bus.i_valid = 1'b1;
                bus.i_data  = d;
                bus.i_last  = lst;
            end
            cycle();
            done = m_accepted;
            tries++;
            if (!done && tries > 200) begin
                check("beat_timeout", tries, 0);
                done = 1'b1;
            end
        end
    endtask

    task automatic send_pair(input beats_t a, input beats_t b, input int gap_pct);
        for (int k = 0; k < BEATS; k++) send_beat(a[k], 1'b0, gap_pct);
        for (int k = 0; k < BEATS; k++) send_beat(b[k], 1'b0, gap_pct);
    endtask

    task automatic idle();
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        cycle();
    endtask

    task automatic rand_beats(output beats_t v);
        for (int k = 0; k < BEATS; k++) v[k] = $urandom;
    endtask

    initial begin
        beats_t               va, vb;
        logic [3:0]           nib;
        logic [VEC_WIDTH-1:0] snap_a;

        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_last  = 1'b0;
        bus.i_ready = 1'b1;
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        check("rst_o_a", bus.o_a, '0);
        check("rst_o_b", bus.o_b, '0);

        // Constant-pattern pair, valid visible for exactly one cycle.
        for (int k = 0; k < BEATS; k++) va[k] = 32'h11111111;
        for (int k = 0; k < BEATS; k++) vb[k] = 32'h22222222;
        send_pair(va, vb, 0);
        check("t1_a", bus.o_a, {VEC_SIZE{4'h1}});
        check("t1_b", bus.o_b, {VEC_SIZE{4'h2}});
        idle();

        // Beat/element ordering.
        for (int k = 0; k < BEATS; k++) begin
            nib   = 4'(k);
            va[k] = {8{nib}};
        end
        rand_beats(vb);
        send_pair(va, vb, 0);
        check("t2_a_lo", bus.o_a[31:0], 32'h00000000);
        check("t2_a_hi", bus.o_a[255:224], 32'h77777777);
        idle();

        // Backpressure: hold with input traffic attempting to intrude.
        bus.i_ready = 1'b0;
        rand_beats(va);
        rand_beats(vb);
        send_pair(va, vb, 0);
        snap_a = bus.o_a;
        for (int k = 0; k < 5; k++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = 32'hFFFFFFFF;
            cycle();
            check("hold_a_stable", bus.o_a, snap_a);
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        cycle();
        check("release_valid", bus.o_valid, 1'b0);
        check("release_ready", bus.o_ready, 1'b1);

        // Same data with and without gaps.
        rand_beats(va);
        rand_beats(vb);
        send_pair(va, vb, 0);
        idle();
        send_pair(va, vb, 50);
        idle();

        // Back-to-back pairs: one pair every 2*BEATS+1 cycles.
        rises.delete();
        for (int p = 0; p < 3; p++) begin
            rand_beats(va);
            rand_beats(vb);
            send_pair(va, vb, 0);
        end
        idle();
        check("tput_pairs", rises.size(), 3);
        if (rises.size() == 3) begin
            check("tput_gap0", rises[1] - rises[0], 2*BEATS + 1);
            check("tput_gap1", rises[2] - rises[1], 2*BEATS + 1);
        end

        // Reset during an A load discards the partial vector.
        for (int k = 0; k < 5; k++) send_beat($urandom, 1'b0, 0);
        bus.i_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < BEATS; k++) va[k] = 32'hAAAAAAAA;
        for (int k = 0; k < BEATS; k++) vb[k] = 32'h55555555;
        send_pair(va, vb, 0);
        check("rst_beats", acc_since_rst, 2*BEATS);
        check("rst_pair_a", bus.o_a, {(VEC_WIDTH/4){4'hA}});
        idle();

        // Random traffic with random downstream stalls.
        for (int p = 0; p < 4; p++) begin
            bus.i_ready = 1'b0;
            rand_beats(va);
            rand_beats(vb);
            send_pair(va, vb, 50);
            repeat ($urandom_range(3)) begin
                bus.i_valid = $urandom_range(1);
                bus.i_data  = $urandom;
                cycle();
            end
            bus.i_valid = 1'b0;
            bus.i_ready = 1'b1;
            cycle();
        end

`ifdef VEC_OPERAND_LOADER_ZERO_PAD_EN
        // Short A vector padded with zeros.
        acc_since_rst = 0;
        send_beat(32'h77777777, 1'b0, 0);
        send_beat(32'h77777777, 1'b1, 0);
        for (int k = 0; k < BEATS; k++) send_beat(32'h11111111, 1'b0, 0);
        check("pad_a_lo", bus.o_a[63:0], 64'h7777777777777777);
        check("pad_a_hi", bus.o_a[255:64], '0);
        check("pad_beats", acc_since_rst, 10);
        idle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vec_operand_loader.md
Name: vec_operand_loader

Overview:
- Producer side of the dot-product operand interface.
- Accepts a narrow stream of packed signed elements from the memory/fetch side with a valid/ready handshake.
- Assembles one full flattened A vector, then one full flattened B vector.
- Presents both together with a valid/ready handshake to the vector dot-product datapath, holding them stable until accepted.

Parameters:
- BIT_WIDTH, 4, bits per signed element.
- VEC_SIZE, 64, elements per vector.
- BUS_WIDTH, 32, input beat width. Must be a multiple of BIT_WIDTH, and VEC_SIZE*BIT_WIDTH must be a multiple of BUS_WIDTH.
- VEC_WIDTH, BIT_WIDTH*VEC_SIZE (256), derived; flattened vector width.
- BEATS, VEC_WIDTH/BUS_WIDTH (8), derived; beats per vector.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- i_valid  input  1  input beat valid.
- o_ready  output  1  loader can accept a beat.
- i_data  input  BUS_WIDTH  packed elements; element k of the beat at bits [k*BIT_WIDTH +: BIT_WIDTH].
- i_last  input  1  final beat of the current vector; used only with the optional feature.
- o_valid  output  1  o_a/o_b pair valid.
- i_ready  input  1  downstream accepts the pair.
- o_a  output  VEC_WIDTH  flattened A; element n at bits [n*BIT_WIDTH +: BIT_WIDTH].
- o_b  output  VEC_WIDTH  flattened B, same layout.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: state=S_LOAD_A, beat_cnt=0, o_valid=0, o_a=0, o_b=0.
  - Reset mid-load or mid-output discards all partial or pending data.
  - o_valid=0 in the cycle after i_rst is sampled high.
- States:
  - S_LOAD_A: o_ready=1.
  - S_LOAD_B: o_ready=1.
  - S_OUT: o_ready=0, o_valid=1.
- o_ready is decoded combinationally from state only. It never depends on i_valid.
- Beat accept = i_valid && o_ready on a rising edge.
  - In S_LOAD_A, i_data is written to o_a[beat_cnt*BUS_WIDTH +: BUS_WIDTH].
  - In S_LOAD_B, i_data is written to o_b the same way.
  - beat_cnt then increments. beat_cnt width is clog2(BEATS), minimum 1 bit.
- Transitions:
  - When beat_cnt==BEATS-1 and a beat is accepted: beat_cnt wraps to 0. S_LOAD_A goes to S_LOAD_B; S_LOAD_B goes to S_OUT.
  - i_valid low leaves state, counter and buffers unchanged. Gaps are allowed anywhere.
  - S_OUT: o_a/o_b are held bit-stable while o_valid=1. i_valid is ignored.
  - When i_ready=1 in S_OUT: go to S_LOAD_A; o_valid=0 next cycle.
  - If o_valid and i_ready are both high, the pair counts as transferred on that edge.
- Latency: o_valid rises the cycle after the last B beat is accepted.
- Throughput: minimum 2*BEATS+1 cycles per pair (17 at defaults) with continuous i_valid and i_ready=1.
- o_a/o_b content outside S_OUT is don't-care for downstream. Buffers are not cleared between pairs; full loads overwrite every bit.
- Arithmetic: none. Bit placement is a pure pass-through. Signedness is interpreted only downstream.

Optional Feature:
- Macro: VEC_OPERAND_LOADER_ZERO_PAD_EN.
- Defined:
  - Accepting a beat with i_last=1 and beat_cnt<BEATS-1 ends the current vector early.
  - That beat is written normally.
  - All higher bits of the current buffer are set to 0 on the same edge, so padded elements contribute 0 to the dot product.
  - beat_cnt goes to 0 and the state advances exactly as for a full vector.
  - i_last on beat BEATS-1 behaves as a normal final beat.
- Undefined: i_last is ignored; every vector is exactly BEATS beats.

Test Plan:
- Reset, then 8 beats of 0x11111111 followed by 8 beats of 0x22222222, i_ready=1 -> o_valid high for exactly 1 cycle, the cycle after beat 16. In that cycle o_a={64{4'h1}} and o_b={64{4'h2}}; o_ready=0 in that cycle.
- Beat k of A = 32'h(k)(k)(k)(k)(k)(k)(k)(k) for k=0..7 -> o_a[31:0]=0x00000000 and o_a[255:224]=0x77777777. Confirms beat and element ordering.
- Pair loaded, i_ready=0 for 5 cycles with i_valid=1 and i_data=0xFFFFFFFF -> o_valid and o_a/o_b stable all 5 cycles, o_ready=0, buffers unchanged. With i_ready=1 -> o_valid=0 next cycle, o_ready=1.
- Random i_valid gaps (~50% duty) across a full pair -> same o_a/o_b as the gap-free run. Continuous i_valid with i_ready=1 -> o_valid pulses every 17 cycles.
- i_rst pulsed after 5 A beats, then a clean full pair of 0xAAAAAAAA/0x55555555 -> o_valid only after 16 post-reset beats, with correct data.
- With ZERO_PAD_EN: 2 A beats of 0x77777777 with i_last on the 2nd, then 8 B beats of 0x11111111 -> o_a[63:0]=all 7s, o_a[255:64]=0, o_valid after 10 accepted beats total.
